pixel_concat: RTL and testbench

PIXEL_CONCAT -- requirements
Module: pixel_concat

---
 rtl/pixel_concat.sv | 106 ++++++++++
 tb/tb_pixel_concat.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_concat.sv
// pixel_concat: packs NUM consecutive input words into one wide output beat.
// A one-word skid register absorbs the single word that may arrive in the
// cycle after ostall rises, so the upstream only needs a registered stall.
module pixel_concat #(
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned NUM       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DAT_WIDTH-1:0]     idat,
  input  logic                     ival,
  output logic                     ostall,
  output logic [DAT_WIDTH*NUM-1:0] odat,
  output logic                     oval,
  input  logic                     ordy
);

  localparam int unsigned CntW = $clog2(NUM + 1);
  localparam logic [CntW-1:0] Full = CntW'(NUM);

  logic [DAT_WIDTH*NUM-1:0] acc_q, acc_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0]     skid_q, skid_d;
  logic                     skid_v_q, skid_v_d;
  logic [DAT_WIDTH*NUM-1:0] odat_q, odat_d;
  logic                     oval_q, oval_d;
  logic                     xfer;

  // A full accumulator moves to the output register when that register is empty or draining.
  assign xfer   = (cnt_q == Full) && (!oval_q || ordy);
  assign ostall = skid_v_q || ((cnt_q == Full) && oval_q && !ordy);
  assign odat   = odat_q;
  assign oval   = oval_q;

  // Next state: transfer first, then drain skid, then place the incoming word.
  always_comb begin : next_state
    logic [CntW-1:0] slot;
    acc_d    = acc_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    odat_d   = odat_q;
    oval_d   = oval_q;

    if (xfer) begin
      odat_d = acc_q;
      oval_d = 1'b1;
      slot   = '0;
    end else begin
      slot = cnt_q;
      if (oval_q && ordy) begin
        oval_d = 1'b0;
      end
    end

    // The skid word is always older than any word arriving this cycle.
    if (skid_v_q && (slot != Full)) begin
      for (int k = 0; k < int'(NUM); k++) begin
        if (CntW'(k) == slot) begin
          acc_d[k*DAT_WIDTH +: DAT_WIDTH] = skid_q;
        end
      end
      slot     = slot + CntW'(1);
      skid_v_d = 1'b0;
    end

    if (ival) begin
      if (slot != Full) begin
        for (int k = 0; k < int'(NUM); k++) begin
          if (CntW'(k) == slot) begin
            acc_d[k*DAT_WIDTH +: DAT_WIDTH] = idat;
          end
        end
        slot = slot + CntW'(1);
      end else begin
        skid_d   = idat;
        skid_v_d = 1'b1;
      end
    end

    cnt_d = slot;
  end

  // State registers; reset drops any partial beat and the skid word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      odat_q   <= '0;
      oval_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      odat_q   <= odat_d;
      oval_q   <= oval_d;
    end
  end

  // An upstream that ignores ostall would overwrite the occupied skid register.
  ival_while_skid_a: assert property (@(posedge clk) disable iff (rst) !(ival && skid_v_q))
    else $error("pixel_concat: ival asserted while skid register occupied");

endmodule

// File: tb/tb_pixel_concat.sv
// Bench for pixel_concat: a queue of accepted words predicts every output beat.
module tb_pixel_concat;

  logic         clk;
  logic         rst;
  logic [31:0]  idat;
  logic         ival;
  logic         ostall;
  logic [127:0] odat;
  logic         oval;
  logic         ordy;

  logic [31:0]  idat2;
  logic         ival2;
  logic         ostall2;
  logic [63:0]  odat2;
  logic         oval2;
  logic         ordy2;

  int           n_cmp;
  int           n_err;
  int           beats_out;
  int           next_word;
  logic         stall_prev;
  logic         hold_prev;
  logic [127:0] prev_odat;
  logic [31:0]  q[$];

  pixel_concat #(.DAT_WIDTH(32), .NUM(4)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .idat   (idat),
    .ival   (ival),
    .ostall (ostall),
    .odat   (odat),
    .oval   (oval),
    .ordy   (ordy)
  );

  pixel_concat #(.DAT_WIDTH(32), .NUM(2)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .idat   (idat2),
    .ival   (ival2),
    .ostall (ostall2),
    .odat   (odat2),
    .oval   (oval2),
    .ordy   (ordy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: each beat is the next four accepted words, oldest in the LSBs.
  always @(negedge clk) begin : mon
    logic [127:0] eb;
    if (rst) begin
      q.delete();
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_val", oval, 1);
        check("hold_dat", odat, prev_odat);
      end
      if (ostall) check("stall_cause", (oval && !ordy) || stall_prev, 1);
      if (oval && ordy) begin
        check("beat_avail", q.size() >= 4, 1);
        if (q.size() >= 4) begin
          for (int k = 0; k < 4; k++) eb[k*32 +: 32] = q.pop_front();
          check("beat", odat, eb);
          beats_out <= beats_out + 1;
        end
      end
      if (ival) q.push_back(idat);
      hold_prev <= oval && !ordy;
    end
    prev_odat  <= odat;
    stall_prev <= ostall;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst   = 1'b1;
    ival  = 1'b0;
    ival2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Upstream counter generator: obeys the one-cycle-late ostall rule.
  task automatic run(input int cycles, input int p_ival, input int rdy_mode, input int last_word);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ordy = 1'b0;
        1:       ordy = 1'b1;
        2:       ordy = 1'($urandom_range(1));
        default: ordy = !ordy;
      endcase
      if (!stall_prev && next_word <= last_word && int'($urandom_range(99)) < p_ival) begin
        ival = 1'b1;
        idat = 32'(next_word);
        next_word++;
      end else begin
        ival = 1'b0;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; beats_out = 0; next_word = 1;
    rst = 1'b1; ival = 1'b0; idat = '0; ordy = 1'b0;
    ival2 = 1'b0; idat2 = '0; ordy2 = 1'b1;
    stall_prev = 1'b0; hold_prev = 1'b0; prev_odat = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_oval", oval, 0);
    check("rst_odat", odat, 0);
    check("rst_ostall", ostall, 0);

    // Continuous input, ordy high: beat every four cycles, first one cycle after word 4
    ordy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      ival = (c < 8);
      idat = 32'(c + 1);
      @(negedge clk);
      check("t1_oval", oval, (c == 5 || c == 9));
      check("t1_ostall", ostall, 0);
      if (c == 5) check("t1_beat1", odat, 128'h00000004_00000003_00000002_00000001);
      if (c == 9) check("t1_beat2", odat, 128'h00000008_00000007_00000006_00000005);
    end

    // ordy low: output, accumulator and skid all fill, then drain in order
    do_reset();
    next_word = 1;
    run(15, 100, 0, 9);
    @(negedge clk);
    check("t2_words", q.size(), 9);
    check("t2_oval", oval, 1);
    check("t2_odat", odat, 128'h00000004_00000003_00000002_00000001);
    check("t2_ostall", ostall, 1);
    run(15, 100, 1, 12);
    @(negedge clk);
    check("t2_drained", q.size(), 0);
    check("t2_ostall_low", ostall, 0);
    check("t2_last", odat, 128'h0000000C_0000000B_0000000A_00000009);

    // Bursty input with random ordy
    do_reset();
    next_word = 1;
    beats_out = 0;
    run(10000, 60, 2, 32'h3fff_ffff);
    run(30, 0, 1, 0);
    @(negedge clk);
    check("t3_drained", q.size() < 4, 1);
    check("t3_progress", beats_out > 500, 1);

    // Reset mid-beat discards the partial beat
    do_reset();
    next_word = 1;
    run(2, 100, 1, 2);
    do_reset();
    @(negedge clk);
    check("t4_oval", oval, 0);
    check("t4_ostall", ostall, 0);
    next_word = 10;
    beats_out = 0;
    run(12, 100, 1, 13);
    @(negedge clk);
    check("t4_beats", beats_out, 1);
    check("t4_beat", odat, 128'h0000000D_0000000C_0000000B_0000000A);

    // ordy toggling every cycle with continuous input
    do_reset();
    next_word = 1;
    ordy = 1'b0;
    beats_out = 0;
    run(400, 100, 3, 32'h3fff_ffff);
    run(20, 0, 1, 0);
    @(negedge clk);
    check("t5_drained", q.size() < 4, 1);
    check("t5_progress", beats_out > 40, 1);

    // NUM=2 instance: beat every two cycles, each presented for one cycle
    do_reset();
    ordy2 = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      ival2 = (c < 8);
      idat2 = 32'(c + 1);
      @(negedge clk);
      check("t6_oval", oval2, (c >= 3 && c <= 9 && (c % 2) == 1));
      check("t6_ostall", ostall2, 0);
      if (c >= 3 && c <= 9 && (c % 2) == 1) begin
        check("t6_beat", odat2, {32'(c - 1), 32'(c - 2)});
      end
    end
    ival2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
